// File: rtl/bnn_conv3x3_multi.sv
// ---------------------------------------------------------------------------
// bnn_conv3x3_multi
//
// Multi-kernel binary 3x3 convolution engine. Streams square binary images
// (header word N followed by N row words) from the input SRAM. Each 3x3 window
// is XNOR-popcount compared against up to NUM_K kernels. The resulting output
// rows are written as packed words, kernel-interleaved (row r: kernel 0..K-1).
//
// Optional feature: define BNN_CONV_THRESH_EN to use per-kernel thresholds
// from weight word bits[12:9]. When it is undefined, every kernel uses a
// majority-vote threshold of 5.
//
// Parameters
//   MAX_DIM  largest image edge N (<=16)
//   NUM_K    number of kernels supported (1..8)
//   ADDR_W   SRAM address width
//
// Ports
//   clk, reset_b                 clock, asynchronous active-low reset
//   dut_run                      start request, sampled in IDLE only
//   dut_busy                     high while a job is in progress
//   dut_sram_read_address        input SRAM address (data one cycle later)
//   sram_dut_read_data           input SRAM data
//   dut_sram_write_address/_data/_enable   output row word write port
//   dut_wmem_read_address        weight SRAM address (data one cycle later)
//   wmem_dut_read_data           weight SRAM data
// ---------------------------------------------------------------------------
module bnn_conv3x3_multi #(
    parameter int MAX_DIM = 16,
    parameter int NUM_K   = 2,
    parameter int ADDR_W  = 12
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [15:0]       sram_dut_read_data,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [15:0]       dut_sram_write_data,
    output logic              dut_sram_write_enable,
    output logic [ADDR_W-1:0] dut_wmem_read_address,
    input  logic [15:0]       wmem_dut_read_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_HDR, S_FILL, S_OUT, S_SHIFT, S_DONE
    } state_t;

    // Active kernel count from weight word 0: 0 means 1, large values clamp.
    function automatic logic [3:0] clamp_k(input logic [3:0] raw);
        if (raw == 4'd0)
            return 4'd1;
        else if (raw > 4'(NUM_K))
            return 4'(NUM_K);
        else
            return raw;
    endfunction

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 9; i++)
            s = s + 4'(v[i]);
        return s;
    endfunction

    state_t              r_state;
    state_t              w_next;

    logic                r_busy;
    logic [ADDR_W-1:0]   r_raddr;
    logic [ADDR_W-1:0]   r_waddr;
    logic [ADDR_W-1:0]   r_wa;
    logic [ADDR_W-1:0]   r_wr_cnt;
    logic [15:0]         r_wd;
    logic                r_we;
    logic [3:0]          r_k;
    logic [3:0]          r_widx;
    logic [1:0]          r_cnt;
    logic [4:0]          r_row;
    logic [4:0]          r_n;
    logic [3:0]          r_kidx;

    logic [MAX_DIM-1:0]  r_win0;
    logic [MAX_DIM-1:0]  r_win1;
    logic [MAX_DIM-1:0]  r_win2;
    logic [8:0]          r_wgt [NUM_K];

    logic                w_hdr_term;
    logic                w_last_k;
    logic                w_last_row;
    logic [8:0]          w_sel_w;
    logic [3:0]          w_thr;
    logic [15:0]         w_out_word;

    assign dut_busy               = r_busy;
    assign dut_sram_read_address  = r_raddr;
    assign dut_wmem_read_address  = r_waddr;
    assign dut_sram_write_address = r_wa;
    assign dut_sram_write_data    = r_wd;
    assign dut_sram_write_enable  = r_we;

    // The 00FF terminator is caught by the N>MAX_DIM test as well.
    assign w_hdr_term = (sram_dut_read_data < 16'd3) ||
                        (sram_dut_read_data > 16'(MAX_DIM));
    assign w_last_k   = (r_kidx == r_k - 4'd1);
    assign w_last_row = (r_row == r_n - 5'd3);

    // Kernel and threshold of the kernel being written this cycle.
    always_comb begin
        w_sel_w = r_wgt[0];
        for (int k = 1; k < NUM_K; k++)
            if (r_kidx == 4'(k))
                w_sel_w = r_wgt[k];
    end

`ifdef BNN_CONV_THRESH_EN
    logic [3:0] r_thr [NUM_K];
    logic       w_unused;
    assign w_unused = &{1'b0, wmem_dut_read_data[15:13]};

    always_comb begin
        w_thr = r_thr[0];
        for (int k = 1; k < NUM_K; k++)
            if (r_kidx == 4'(k))
                w_thr = r_thr[k];
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_K; k++)
            if (r_state == S_LOAD_W && r_widx == 4'(k + 1))
                r_thr[k] <= wmem_dut_read_data[12:9];
    end
`else
    logic w_unused;
    assign w_unused = &{1'b0, wmem_dut_read_data[15:9]};
    assign w_thr    = 4'd5;
`endif

    // One output bit per window position; positions past N-3 stay 0.
    always_comb begin
        w_out_word = '0;
        for (int j = 0; j < MAX_DIM - 2; j++) begin
            if (5'(j) + 5'd3 <= r_n)
                w_out_word[j] = (popcount9(~(w_sel_w ^ {r_win2[j +: 3],
                                                         r_win1[j +: 3],
                                                         r_win0[j +: 3]})) >= w_thr);
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (dut_run) w_next = S_LOAD_W;
            // r_k is only valid once word 0 has been captured (r_widx != 0).
            S_LOAD_W: if (r_widx != 4'd0 && r_widx == r_k) w_next = S_HDR;
            S_HDR:    w_next = w_hdr_term ? S_DONE : S_FILL;
            S_FILL:   if (r_cnt == 2'd3) w_next = S_OUT;
            S_OUT:    if (w_last_k) w_next = w_last_row ? S_HDR : S_SHIFT;
            S_SHIFT:  w_next = S_OUT;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Read addresses are kept one word ahead: the word a state consumes has
    // been on the address bus for at least one cycle before it is used.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_busy   <= 1'b0;
            r_raddr  <= '0;
            r_waddr  <= '0;
            r_wa     <= '0;
            r_wr_cnt <= '0;
            r_wd     <= '0;
            r_we     <= 1'b0;
            r_k      <= 4'd1;
            r_widx   <= '0;
            r_cnt    <= '0;
            r_row    <= '0;
            r_n      <= '0;
            r_kidx   <= '0;
        end else begin
            r_we <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_raddr <= '0;
                    r_waddr <= '0;
                    if (dut_run) begin
                        r_busy   <= 1'b1;
                        r_waddr  <= ADDR_W'(1);
                        r_widx   <= '0;
                        r_wr_cnt <= '0;
                    end
                end
                S_LOAD_W: begin
                    r_widx  <= r_widx + 4'd1;
                    r_waddr <= r_waddr + 1'b1;
                    if (r_widx == 4'd0)
                        r_k <= clamp_k(wmem_dut_read_data[3:0]);
                end
                S_HDR: begin
                    r_n    <= sram_dut_read_data[4:0];
                    r_cnt  <= '0;
                    r_row  <= '0;
                    if (!w_hdr_term)
                        r_raddr <= r_raddr + 1'b1;
                end
                S_FILL: begin
                    // Cycle 0 only primes the read; cycles 1..3 consume rows.
                    r_cnt  <= r_cnt + 2'd1;
                    r_kidx <= '0;
                    if (r_cnt != 2'd3)
                        r_raddr <= r_raddr + 1'b1;
                end
                S_OUT: begin
                    r_we     <= 1'b1;
                    r_wa     <= r_wr_cnt;
                    r_wd     <= w_out_word;
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                    r_kidx   <= w_last_k ? 4'd0 : r_kidx + 4'd1;
                    if (w_last_k && !w_last_row)
                        r_row <= r_row + 5'd1;
                end
                S_SHIFT: r_raddr <= r_raddr + 1'b1;
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_raddr <= '0;
                    r_waddr <= '0;
                end
                default: ;
            endcase
        end
    end

    // Window rows and kernel weights: datapath only, no reset needed.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_K; k++)
            if (r_state == S_LOAD_W && r_widx == 4'(k + 1))
                r_wgt[k] <= wmem_dut_read_data[8:0];
        if ((r_state == S_FILL && r_cnt != 2'd0) || r_state == S_SHIFT) begin
            r_win0 <= r_win1;
            r_win1 <= r_win2;
            r_win2 <= sram_dut_read_data[MAX_DIM-1:0];
        end
    end

endmodule

// File: tb/tb_bnn_conv3x3_multi.sv
`timescale 1ns/1ps
module tb_bnn_conv3x3_multi;

    localparam int MAXD = 16;
    localparam int NK   = 3;
    localparam int AW   = 12;

    logic          clk = 1'b0;
    logic          reset_b = 1'b0;
    logic          dut_run = 1'b0;
    logic          dut_busy;
    logic [AW-1:0] dut_sram_read_address;
    logic [15:0]   sram_dut_read_data;
    logic [AW-1:0] dut_sram_write_address;
    logic [15:0]   dut_sram_write_data;
    logic          dut_sram_write_enable;
    logic [AW-1:0] dut_wmem_read_address;
    logic [15:0]   wmem_dut_read_data;

    logic [15:0] imem [0:4095];
    logic [15:0] wmem [0:4095];

    int n_chk  = 0;
    int n_pass = 0;
    int viol   = 0;
    int cyc    = 0;
    int t_acc;
    int t_fall;
    int eff_k;
    logic timed_out;

    logic [15:0] wa_q [$];
    logic [15:0] wd_q [$];
    int          wc_q [$];
    logic [15:0] exp_q [$];

    bnn_conv3x3_multi #(.MAX_DIM(MAXD), .NUM_K(NK), .ADDR_W(AW)) dut (
        .clk                    (clk),
        .reset_b                (reset_b),
        .dut_run                (dut_run),
        .dut_busy               (dut_busy),
        .dut_sram_read_address  (dut_sram_read_address),
        .sram_dut_read_data     (sram_dut_read_data),
        .dut_sram_write_address (dut_sram_write_address),
        .dut_sram_write_data    (dut_sram_write_data),
        .dut_sram_write_enable  (dut_sram_write_enable),
        .dut_wmem_read_address  (dut_wmem_read_address),
        .wmem_dut_read_data     (wmem_dut_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        sram_dut_read_data <= imem[dut_sram_read_address];
        wmem_dut_read_data <= wmem[dut_wmem_read_address];
    end

    always @(negedge clk) begin
        if (dut_sram_write_enable) begin
            wa_q.push_back(16'(dut_sram_write_address));
            wd_q.push_back(dut_sram_write_data);
            wc_q.push_back(cyc);
            if (!dut_busy)
                viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference: walk the records and evaluate every window directly.
    task automatic build_model(output int k_eff);
        int          addr;
        int          n;
        int          cnt;
        int          thr;
        logic [15:0] h;
        logic [15:0] word;
        logic [15:0] row;
        logic [15:0] wt;
        bit          done;
        exp_q.delete();
        k_eff = int'(wmem[0][3:0]);
        if (k_eff == 0) k_eff = 1;
        if (k_eff > NK) k_eff = NK;
        addr = 0;
        done = 0;
        while (!done && addr < 4000) begin
            h = imem[addr];
            addr++;
            if (h == 16'h00FF || h < 16'd3 || h > 16'(MAXD)) begin
                done = 1;
            end else begin
                n = int'(h);
                for (int r = 0; r <= n - 3; r++) begin
                    for (int k = 0; k < k_eff; k++) begin
                        wt = wmem[1 + k];
`ifdef BNN_CONV_THRESH_EN
                        thr = int'(wt[12:9]);
`else
                        thr = 5;
`endif
                        word = '0;
                        for (int j = 0; j <= n - 3; j++) begin
                            cnt = 0;
                            for (int dr = 0; dr < 3; dr++) begin
                                row = imem[addr + r + dr];
                                for (int dc = 0; dc < 3; dc++)
                                    if (row[j + dc] == wt[3 * dr + dc]) cnt++;
                            end
                            word[j] = (cnt >= thr);
                        end
                        exp_q.push_back(word);
                    end
                end
                addr += n;
            end
        end
    endtask

    task automatic put_image(input int base, input int n, input int pat, output int nxt);
        imem[base] = 16'(n);
        for (int r = 0; r < n; r++) begin
            case (pat)
                1:       imem[base + 1 + r] = 16'hFFFF;
                2:       imem[base + 1 + r] = (r % 2 == 0) ? 16'hAAAA : 16'h5555;
                default: imem[base + 1 + r] = 16'($urandom);
            endcase
        end
        nxt = base + 1 + n;
    endtask

    task automatic start_run();
        @(negedge clk);
        dut_run = 1'b1;
        @(posedge clk);
        #1;
        t_acc = cyc;
        dut_run = 1'b0;
    endtask

    task automatic run_job(input string tag, input bit poke);
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        viol = 0;
        build_model(eff_k);
        start_run();
        check({tag, "_busy_rise"}, 32'(dut_busy), 32'd1);
        timed_out = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            #1;
            dut_run = (poke && i == 3);
            if (!dut_busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        dut_run = 1'b0;
        t_fall = cyc;
        check({tag, "_timeout"}, 32'(timed_out), 32'd0);
        check({tag, "_nwr"}, 32'(wd_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < wd_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wa_q[i]), 32'(i));
            check($sformatf("%s_data%0d", tag, i), 32'(wd_q[i]), 32'(exp_q[i]));
            if (i % eff_k != 0)
                check($sformatf("%s_burst%0d", tag, i), 32'(wc_q[i] - wc_q[i - 1]), 32'd1);
        end
        if (wd_q.size() > 0) begin
            check({tag, "_first_lat_ok"}, 32'(wc_q[0] - t_acc <= eff_k + 12), 32'd1);
            check({tag, "_busy_fall_ok"}, 32'(t_fall - wc_q[wc_q.size() - 1] <= 4), 32'd1);
        end else begin
            check({tag, "_idle_fall_ok"}, 32'(t_fall - t_acc <= eff_k + 12), 32'd1);
        end
        check({tag, "_we_without_busy"}, 32'(viol), 32'd0);
    endtask

    initial begin
        int a;
        int nrec;
        int sel;
        logic [15:0] terms [5];
        terms[0] = 16'h00FF; terms[1] = 16'h0000; terms[2] = 16'h0002;
        terms[3] = 16'h0011; terms[4] = 16'h1234;
        for (int i = 0; i < 4096; i++) begin
            imem[i] = 16'h00FF;
            wmem[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  32'(dut_busy), 32'd0);
        check("rst_we",    32'(dut_sram_write_enable), 32'd0);
        check("rst_raddr", 32'(dut_sram_read_address), 32'd0);
        check("rst_waddr", 32'(dut_sram_write_address), 32'd0);
        check("rst_wdata", 32'(dut_sram_write_data), 32'd0);
        check("rst_wmaddr", 32'(dut_wmem_read_address), 32'd0);
        @(negedge clk);
        reset_b = 1'b1;

        // Single image, K=1, all ones
        wmem[0] = 16'd1;
        wmem[1] = {3'b0, 4'd5, 9'h1FF};
        put_image(0, 10, 1, a);
        imem[a] = 16'h00FF;
        run_job("single", 1'b0);
        check("single_cnt", 32'(wd_q.size()), 32'd8);
        foreach (wd_q[i])
            check($sformatf("single_word%0d", i), 32'(wd_q[i]), 32'h00FF);
        @(negedge clk);
        check("single_busy_low", 32'(dut_busy), 32'd0);

        // Threshold sweep on a checkerboard
        wmem[0] = 16'd2;
        wmem[1] = {3'b0, 4'd0, 9'(  $urandom)};
        wmem[2] = {3'b0, 4'd10, 9'($urandom)};
        put_image(0, 12, 2, a);
        imem[a] = 16'h00FF;
        run_job("sweep", 1'b1);
        check("sweep_cnt", 32'(wd_q.size()), 32'd20);

        // Three images, K=3
        wmem[0] = 16'd3;
        for (int k = 1; k <= 3; k++) wmem[k] = 16'($urandom);
        put_image(0, 16, 0, a);
        put_image(a, 10, 0, a);
        put_image(a, 12, 0, a);
        imem[a] = 16'h00FF;
        run_job("multi", 1'b0);
        check("multi_cnt", 32'(wd_q.size()), 32'd96);

        // Kernel-count clamp (15 -> NK), then an illegal first header
        wmem[0] = 16'h000F;
        put_image(0, 5, 0, a);
        imem[a] = 16'h0002;
        run_job("clamp", 1'b0);
        check("clamp_cnt", 32'(wd_q.size()), 32'(3 * NK));
        imem[0] = 16'h0002;
        run_job("illegal", 1'b0);
        check("illegal_cnt", 32'(wd_q.size()), 32'd0);

        // Reset in the middle of writing
        wmem[0] = 16'd3;
        put_image(0, 16, 0, a);
        put_image(a, 10, 0, a);
        imem[a] = 16'h00FF;
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        start_run();
        timed_out = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (wd_q.size() >= 5) begin
                timed_out = 1'b0;
                break;
            end
        end
        check("rstmid_reach5", 32'(timed_out), 32'd0);
        reset_b = 1'b0;
        #1;
        check("rstmid_busy",  32'(dut_busy), 32'd0);
        check("rstmid_we",    32'(dut_sram_write_enable), 32'd0);
        check("rstmid_raddr", 32'(dut_sram_read_address), 32'd0);
        check("rstmid_waddr", 32'(dut_sram_write_address), 32'd0);
        check("rstmid_wdata", 32'(dut_sram_write_data), 32'd0);
        check("rstmid_wmaddr", 32'(dut_wmem_read_address), 32'd0);
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        run_job("rerun", 1'b0);

        // Randomized jobs
        for (int job = 0; job < 6; job++) begin
            wmem[0] = 16'($urandom_range(0, 15));
            for (int k = 1; k <= 8; k++) wmem[k] = 16'($urandom);
            nrec = $urandom_range(0, 3);
            a = 0;
            for (int r = 0; r < nrec; r++)
                put_image(a, $urandom_range(3, MAXD), 0, a);
            sel = $urandom_range(0, 4);
            imem[a] = terms[sel];
            run_job($sformatf("rand%0d", job), (nrec > 0) && ($urandom_range(0, 1) == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
